decimal_char_tx: RTL and testbench

DECIMAL_CHAR_TX -- requirements
Module: decimal_char_tx

---
 rtl/decimal_char_tx.sv | 83 ++++++++
 tb/tb_decimal_char_tx.sv | 136 +++++++++++++
 2 files changed

// File: rtl/decimal_char_tx.sv
// decimal_char_tx: converts a 32-bit value to ASCII decimal via double-dabble and streams it with a terminator.
// Optional macro DECIMAL_CHAR_TX_CRLF_EN emits CR before TERM_CHAR.
module decimal_char_tx #(
  parameter logic [7:0] TERM_CHAR = 8'd10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [31:0] value,
  output logic        char_valid,
  input  logic        char_ready,
  output logic [7:0]  char_out,
  output logic        busy
);
  localparam logic [1:0] IDLE = 2'd0, CONVERT = 2'd1, EMIT = 2'd2, TERM = 2'd3;
  logic [1:0]  state;
  logic [31:0] sh;
  logic [39:0] bcd, bcd_nx;
  logic [4:0]  cnt;
  logic [3:0]  ptr, msd, digit;
  logic [7:0]  term_ch;
`ifdef DECIMAL_CHAR_TX_CRLF_EN
  logic cr;
  assign term_ch = cr ? TERM_CHAR : 8'd13;
`else
  assign term_ch = TERM_CHAR;
`endif
  always_comb begin
    bcd_nx = bcd;
    for (int i = 0; i < 10; i++) bcd_nx[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    bcd_nx = {bcd_nx[38:0], sh[31]};
    msd = 4'd0;
    for (int i = 0; i < 10; i++) if (bcd_nx[4*i +: 4] != 4'd0) msd = i[3:0];
  end
  assign start_ready = state == IDLE;
  assign busy        = state != IDLE;
  assign char_valid  = state == EMIT || state == TERM;
  assign digit       = bcd[{ptr, 2'b00} +: 4];
  assign char_out    = state == EMIT ? 8'd48 + {4'd0, digit} : state == TERM ? term_ch : 8'd0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sh    <= '0;
      bcd   <= '0;
      cnt   <= '0;
      ptr   <= '0;
`ifdef DECIMAL_CHAR_TX_CRLF_EN
      cr    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start_valid) begin
          sh    <= value;
          bcd   <= '0;
          cnt   <= '0;
          state <= CONVERT;
        end
        CONVERT: begin
          bcd <= bcd_nx;
          sh  <= {sh[30:0], 1'b0};
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            ptr   <= msd;
            state <= EMIT;
          end
        end
        EMIT: if (char_ready) begin
          ptr <= ptr - 4'd1;
          if (ptr == 4'd0) state <= TERM;
        end
        default: if (char_ready) begin
`ifdef DECIMAL_CHAR_TX_CRLF_EN
          cr <= !cr;
          if (cr) state <= IDLE;
`else
          state <= IDLE;
`endif
        end
      endcase
    end
  end
endmodule

// File: tb/tb_decimal_char_tx.sv
// tb_decimal_char_tx: scoreboard bench; the reference model formats values with $sformatf.
module tb_decimal_char_tx;
  logic clk = 0, rst_n = 0, start_valid = 0, char_ready = 0;
  logic [31:0] value = 0;
  logic start_ready, char_valid, busy;
  logic [7:0] char_out;
  logic [7:0] exp_q[$];
  int total = 0, passed = 0, hs = 0, lat, base;
  bit rnd_rdy = 0;
`ifdef DECIMAL_CHAR_TX_CRLF_EN
  localparam int CR = 1;
`else
  localparam int CR = 0;
`endif

  decimal_char_tx dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .value(value), .char_valid(char_valid), .char_ready(char_ready),
    .char_out(char_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic void model(input logic [31:0] v);
    string s = $sformatf("%0d", v);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    if (CR == 1) exp_q.push_back(8'd13);
    exp_q.push_back(8'd10);
  endfunction

  // Inputs change on the falling edge, so sampling 2ns later sees what the next rising edge will see.
  initial begin
    bit stall = 0;
    logic [7:0] held = 0;
    forever begin
      @(negedge clk);
      #2;
      if (stall) check("hold", {23'd0, char_valid, char_out}, {23'd0, 1'b1, held});
      stall = char_valid && !char_ready;
      held  = char_out;
      if (char_valid && char_ready) begin
        hs++;
        if (exp_q.size() == 0) check("unexpected_char", {24'd0, char_out}, 32'hFFFF);
        else check("char", {24'd0, char_out}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rnd_rdy) char_ready = 1'($urandom_range(0, 1));
  end

  task automatic send(input logic [31:0] v);
    int n = 0;
    @(negedge clk);
    value = v;
    start_valid = 1;
    while (!start_ready && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) check("accept_timeout", 0, 1);
    model(v);
    @(negedge clk);
    start_valid = 0;
    value = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((!start_ready || exp_q.size() != 0) && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) check("idle_timeout", 0, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_start_ready", start_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_char_valid", char_valid, 0);
    check("rst_char_out", char_out, 0);
    rst_n = 1;
    char_ready = 1;
    send(142);
    check("busy142", busy, 1);
    lat = 0;
    while (!char_valid && lat < 100) begin @(negedge clk); lat++; end
    check("latency142", lat, 32);
    for (int k = 0; k < 4 + CR; k++) begin check("valid142", char_valid, 1); @(negedge clk); end
    check("start_ready142", start_ready, 1);
    wait_idle();
    base = hs;
    send(0);
    wait_idle();
    check("hs_zero", hs - base, 2 + CR);
    base = hs;
    send(32'hFFFFFFFF);
    wait_idle();
    check("hs_max", hs - base, 11 + CR);
    char_ready = 0;
    send(77);
    lat = 0;
    while (!char_valid && lat < 100) begin @(negedge clk); lat++; end
    for (int k = 0; k < 5; k++) begin
      check("stall77", {23'd0, char_valid, char_out}, {23'd0, 1'b1, 8'd55});
      @(negedge clk);
    end
    char_ready = 1;
    wait_idle();
    base = hs;
    send(12345);
    lat = 0;
    while (hs < base + 2 && lat < 200) begin @(negedge clk); lat++; end
    #1 rst_n = 0;
    #1;
    check("abort_char_valid", char_valid, 0);
    check("abort_start_ready", start_ready, 1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1;
    send(9);
    wait_idle();
    send(5);
    wait_idle();
    rnd_rdy = 1;
    for (int k = 0; k < 40; k++) send($urandom >> $urandom_range(0, 31));
    wait_idle();
    rnd_rdy = 0;
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
